// File: rtl/stream_fifo.sv
// ---------------------------------------------------------------------------
// stream_fifo
//   Valid/ready stream FIFO with first-word-fall-through output stage.
//   Capacity is 2**DEPTH_LOG2 words in total, counting the output register.
//   Sustains one word per cycle and provides an occupancy count, a registered
//   almost-full flag and a synchronous flush.
//
// Handshake: a word moves across an interface on a rising edge where both
//   valid and ready are 1. Upstream: accept = i_valid & o_ready.
//   Downstream: pop = o_valid & i_ready. o_valid/o_data are held stable while
//   o_valid=1 and i_ready=0. o_ready depends on registered state only.
//
// Ports
//   i_clk          clock, rising edge
//   i_rst          synchronous active-high reset (priority over i_flush)
//   i_flush        synchronous discard of all contents
//   i_data/i_valid upstream data and valid
//   o_ready        upstream ready, high while o_count < 2**DEPTH_LOG2
//   o_data/o_valid downstream data (registered) and valid
//   i_ready        downstream ready
//   o_count        words held, 0..2**DEPTH_LOG2
//   o_almost_full  o_count >= ALMOST_FULL
// ---------------------------------------------------------------------------
module stream_fifo #(
  parameter int DATA_WIDTH  = 8,
  parameter int DEPTH_LOG2  = 4,
  parameter int ALMOST_FULL = 12
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_flush,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_valid,
  output logic                  o_ready,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DEPTH_LOG2:0]   o_count,
  output logic                  o_almost_full
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_C = DEPTH[DEPTH_LOG2:0];
  localparam int unsigned AF_U = ALMOST_FULL;
  localparam logic [DEPTH_LOG2:0] AF_C = AF_U[DEPTH_LOG2:0];

  // Backing store. Only DEPTH-1 entries are ever occupied because the output
  // register holds the oldest word, but a full power-of-two array keeps the
  // pointers wrapping naturally.
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  almost_full_q, almost_full_d;

  logic push;
  logic pop;
  logic ram_empty;
  logic out_load;
  logic ram_rd;
  logic bypass;
  logic ram_wr;

  assign o_ready       = (count_q < DEPTH_C);
  assign o_valid       = out_valid_q;
  assign o_data        = out_data_q;
  assign o_count       = count_q;
  assign o_almost_full = almost_full_q;

  always_comb begin
    push      = i_valid & o_ready;
    pop       = out_valid_q & i_ready;
    // The output stage is always filled first, so words held in the RAM are
    // count minus the output-stage occupancy.
    ram_empty = (count_q == {{DEPTH_LOG2{1'b0}}, out_valid_q});
    // Output register may take a new word when it is empty or being popped.
    out_load  = ~out_valid_q | pop;
    ram_rd    = out_load & ~ram_empty;
    // With nothing queued in the RAM, an incoming word goes straight to the
    // output register; this gives the one-cycle fall-through latency and
    // keeps 1 word/cycle at count=1.
    bypass    = out_load & ram_empty & push;
    ram_wr    = push & ~bypass & ~i_flush & ~i_rst;

    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    count_d     = count_q;

    if (ram_rd) begin
      out_data_d  = mem[rd_ptr_q];
      out_valid_d = 1'b1;
      rd_ptr_d    = rd_ptr_q + 1'b1;
    end else if (bypass) begin
      out_data_d  = i_data;
      out_valid_d = 1'b1;
    end else if (out_load) begin
      out_valid_d = 1'b0;
    end

    if (ram_wr) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (i_flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      out_valid_d = 1'b0;
      count_d     = '0;
    end

    // Derived from the next count so flag and count change on the same edge.
    almost_full_d = (count_d >= AF_C);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      out_valid_q   <= 1'b0;
      almost_full_q <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      out_valid_q   <= out_valid_d;
      almost_full_q <= almost_full_d;
    end
  end

  // Data paths carry no reset; their contents are meaningless while the
  // corresponding valid state is clear.
  always_ff @(posedge i_clk) begin
    out_data_q <= out_data_d;
  end

  always_ff @(posedge i_clk) begin
    if (ram_wr) begin
      mem[wr_ptr_q] <= i_data;
    end
  end

endmodule

// File: tb/tb_stream_fifo.sv
// ---------------------------------------------------------------------------
// tb_stream_fifo
//   Scoreboard bench for stream_fifo (DATA_WIDTH=8, DEPTH_LOG2=4,
//   ALMOST_FULL=12). The driver pushes every accepted word onto exp_q; the
//   monitor pops and compares on every downstream transfer. Directed checks
//   cover reset state, fill/drain, latency, full+pop, streaming, flush/reset.
// ---------------------------------------------------------------------------
module tb_stream_fifo;

  logic       i_clk;
  logic       i_rst;
  logic       i_flush;
  logic [7:0] i_data;
  logic       i_valid;
  logic       o_ready;
  logic [7:0] o_data;
  logic       o_valid;
  logic       i_ready;
  logic [4:0] o_count;
  logic       o_almost_full;

  logic [7:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  stream_fifo #(
    .DATA_WIDTH (8),
    .DEPTH_LOG2 (4),
    .ALMOST_FULL(12)
  ) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_flush      (i_flush),
    .i_data       (i_data),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .o_data       (o_data),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_count      (o_count),
    .o_almost_full(o_almost_full)
  );

  // ---------------- clock / reset block ----------------
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish required finish");
    $fatal(1, "watchdog");
  end

  // ---------------- common check ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Waits to the falling edge and books what the next rising edge will do.
  task automatic sample(output bit accepted);
    @(negedge i_clk);
    accepted = 1'b0;
    if (i_rst || i_flush) begin
      exp_q.delete();
    end else if (i_valid && o_ready) begin
      exp_q.push_back(i_data);
      accepted = 1'b1;
    end
  endtask

  task automatic push_idle_out(input logic [7:0] d);
    bit acc;
    i_valid = 1'b1;
    i_data  = d;
    i_ready = 1'b0;
    sample(acc);
    check("push_accept", acc, 1);
    tick();
    i_valid = 1'b0;
  endtask

  task automatic drain();
    bit acc;
    bit done;
    done    = 1'b0;
    i_valid = 1'b0;
    i_ready = 1'b1;
    for (int k = 0; k < 40 && !done; k++) begin
      sample(acc);
      if (o_count == 5'd0) done = 1'b1;
      tick();
    end
    check("drain_done", done, 1);
    check("drain_exp_left", exp_q.size(), 0);
    i_ready = 1'b0;
  endtask

  // ---------------- scoreboard monitor ----------------
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data  = 8'h00;

  always @(negedge i_clk) begin
    logic [7:0] exp_w;
    if (prev_stall) begin
      check("hold_valid", o_valid, 1);
      check("hold_data", o_data, prev_data);
    end
    prev_stall = o_valid && !i_ready && !i_flush && !i_rst;
    prev_data  = o_data;
    if (o_valid && i_ready && !i_flush && !i_rst) begin
      if (exp_q.size() == 0) begin
        check("unexpected_word", o_data, 32'hFFFF_FFFF);
      end else begin
        exp_w = exp_q.pop_front();
        check("out_data", o_data, exp_w);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bit acc;
    int sent;
    int cyc;

    i_rst   = 1'b1;
    i_flush = 1'b0;
    i_valid = 1'b0;
    i_data  = 8'h00;
    i_ready = 1'b0;
    tick();
    tick();
    i_rst = 1'b0;
    sample(acc);
    check("rst_valid", o_valid, 0);
    check("rst_count", o_count, 0);
    check("rst_af", o_almost_full, 0);
    check("rst_ready", o_ready, 1);
    tick();

    // 1. Fill with downstream stalled, then drain.
    for (int i = 0; i < 16; i++) begin
      i_valid = 1'b1;
      i_data  = 8'(i);
      sample(acc);
      check("fill_ready", o_ready, 1);
      check("fill_count", o_count, i);
      check("fill_af", o_almost_full, (i >= 12));
      tick();
    end
    i_valid = 1'b0;
    sample(acc);
    check("full_count", o_count, 16);
    check("full_ready", o_ready, 0);
    check("full_af", o_almost_full, 1);
    check("full_valid", o_valid, 1);
    check("full_head", o_data, 8'h00);
    tick();
    i_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      sample(acc);
      check("drain_count", o_count, 16 - k);
      check("drain_valid", o_valid, 1);
      check("drain_af", o_almost_full, ((16 - k) >= 12));
      tick();
    end
    sample(acc);
    check("drained_count", o_count, 0);
    check("drained_valid", o_valid, 0);
    check("drained_exp_left", exp_q.size(), 0);
    tick();
    i_ready = 1'b0;

    // 2. Fall-through latency.
    i_valid = 1'b1;
    i_data  = 8'hA5;
    sample(acc);
    check("lat_not_early", o_valid, 0);
    tick();
    i_valid = 1'b0;
    sample(acc);
    check("lat_valid", o_valid, 1);
    check("lat_data", o_data, 8'hA5);
    tick();
    drain();

    // 3. Full with simultaneous push and pop.
    for (int i = 0; i < 16; i++) push_idle_out(8'h20 + 8'(i));
    i_valid = 1'b1;
    i_data  = 8'h30;
    i_ready = 1'b1;
    sample(acc);
    check("fp_no_accept", acc, 0);
    check("fp_count16", o_count, 16);
    tick();
    i_ready = 1'b0;
    sample(acc);
    check("fp_count15", o_count, 15);
    check("fp_accept", acc, 1);
    tick();
    i_valid = 1'b0;
    sample(acc);
    check("fp_count16b", o_count, 16);
    tick();
    drain();

    // 5. Steady streaming from count=1.
    push_idle_out(8'h40);
    for (int k = 0; k < 40; k++) begin
      i_valid = 1'b1;
      i_data  = 8'h41 + 8'(k);
      i_ready = 1'b1;
      sample(acc);
      check("stream_count", o_count, 1);
      check("stream_valid", o_valid, 1);
      check("stream_accept", acc, 1);
      tick();
    end
    drain();

    // 4. Wrap and stress with random handshakes.
    sent = 0;
    cyc  = 0;
    while (sent < 1000 && cyc < 20000) begin
      i_valid = 1'($urandom_range(0, 1));
      i_data  = 8'(sent);
      i_ready = 1'($urandom_range(0, 1));
      sample(acc);
      if (acc) sent++;
      check("stress_count_le16", (o_count <= 5'd16), 1);
      tick();
      cyc++;
    end
    check("stress_all_sent", sent, 1000);
    drain();

    // 6. Flush / reset at count=7 with a simultaneous push.
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 7; i++) push_idle_out(8'h70 + 8'(i));
      sample(acc);
      check("pre_clear_count", o_count, 7);
      tick();
      i_valid = 1'b1;
      i_data  = 8'h55;
      if (m == 0) i_flush = 1'b1;
      else        i_rst   = 1'b1;
      sample(acc);
      tick();
      i_flush = 1'b0;
      i_rst   = 1'b0;
      i_valid = 1'b0;
      sample(acc);
      check("clr_valid", o_valid, 0);
      check("clr_count", o_count, 0);
      check("clr_ready", o_ready, 1);
      check("clr_af", o_almost_full, 0);
      tick();
      push_idle_out(8'h66);
      sample(acc);
      check("clr_first_valid", o_valid, 1);
      check("clr_first_data", o_data, 8'h66);
      tick();
      drain();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
